// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single data-cache port between the scalar load/store unit and
//   the vector address scheduler. One requester owns the port at a time; the
//   grant is held until the cache reports a hit, which is routed back to the
//   owner only. Vector wins arbitration unless it has already taken
//   VEC_BURST_MAX consecutive grants while a scalar request was waiting.
//
//   Optional feature macro: ARB_PERF_CNT_EN adds per-requester stall counters
//   (perf_clr, s_stall_cnt, v_stall_cnt ports).
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   s_ren/s_wen/...     scalar request, address, store data, byte enables
//   s_dhit              scalar access complete
//   v_ren/v_wen/...     vector request, address, store data, byte enables
//   v_abort             vector exception: drop the vector access
//   v_dhit              vector access complete
//   d_ren/d_wen/...     cache request toward the dcache
//   d_hit, d_rdata      cache completion and read data
//   owner               00 none, 01 scalar, 10 vector
//   perf_clr            clear stall counters            (ARB_PERF_CNT_EN)
//   s_stall_cnt         scalar stall cycles, saturating (ARB_PERF_CNT_EN)
//   v_stall_cnt         vector stall cycles, saturating (ARB_PERF_CNT_EN)

module dcache_port_arbiter #(
   parameter int unsigned VEC_BURST_MAX = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             s_ren,
   input  logic             s_wen,
   input  logic [31:0]      s_addr,
   input  logic [31:0]      s_wdata,
   input  logic [3:0]       s_byte_en,
   output logic             s_dhit,
   input  logic             v_ren,
   input  logic             v_wen,
   input  logic [31:0]      v_addr,
   input  logic [31:0]      v_wdata,
   input  logic [3:0]       v_byte_en,
   input  logic             v_abort,
   output logic             v_dhit,
   output logic             d_ren,
   output logic             d_wen,
   output logic [31:0]      d_addr,
   output logic [31:0]      d_wdata,
   output logic [3:0]       d_byte_en,
   input  logic             d_hit,
   input  logic [31:0]      d_rdata,
   output logic [1:0]       owner
`ifdef ARB_PERF_CNT_EN
   ,
   input  logic             perf_clr,
   output logic [CNT_W-1:0] s_stall_cnt,
   output logic [CNT_W-1:0] v_stall_cnt
`endif
);

   // State encoding doubles as the owner debug code.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SCALAR = 2'b01,
      VECTOR = 2'b10
   } state_t;

   localparam int unsigned VCNT_W = $clog2(VEC_BURST_MAX + 1);
   localparam logic [VCNT_W-1:0] VCNT_MAX = VCNT_W'(VEC_BURST_MAX);

   state_t            state, state_nxt;
   logic [VCNT_W-1:0] vcnt, vcnt_nxt;
   logic              s_req, v_req;

   // Read data goes straight from the cache to both requesters outside this
   // block; nothing here consumes it.
   logic unused_rdata;
   assign unused_rdata = ^d_rdata;

   assign s_req = s_ren | s_wen;
   assign v_req = v_ren | v_wen;
   assign owner = state;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         vcnt  <= '0;
      end else begin
         state <= state_nxt;
         vcnt  <= vcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      vcnt_nxt  = vcnt;
      d_ren     = 1'b0;
      d_wen     = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_byte_en = '0;
      s_dhit    = 1'b0;
      v_dhit    = 1'b0;

      case (state)
         IDLE: begin
            if (v_req && !v_abort && (!s_req || vcnt < VCNT_MAX)) begin
               state_nxt = VECTOR;
               // Only grants taken over a waiting scalar count toward the
               // cap; the guard above keeps vcnt below VCNT_MAX here.
               if (s_req) begin
                  vcnt_nxt = vcnt + VCNT_W'(1);
               end
            end else if (s_req) begin
               state_nxt = SCALAR;
               vcnt_nxt  = '0;
            end
            if (!s_req) begin
               vcnt_nxt = '0;
            end
         end

         SCALAR: begin
            // Write wins when both enables are set.
            d_wen     = s_wen;
            d_ren     = s_ren & ~s_wen;
            d_addr    = s_addr;
            d_wdata   = s_wdata;
            d_byte_en = s_byte_en;
            s_dhit    = d_hit;
            if (d_hit) begin
               state_nxt = IDLE;
            end
         end

         VECTOR: begin
            d_addr    = v_addr;
            d_wdata   = v_wdata;
            d_byte_en = v_byte_en;
            // Abort suppresses the strobes and discards any same-cycle hit.
            if (v_abort) begin
               state_nxt = IDLE;
            end else begin
               d_wen  = v_wen;
               d_ren  = v_ren & ~v_wen;
               v_dhit = d_hit;
               if (d_hit) begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef ARB_PERF_CNT_EN
   logic s_stall, v_stall;

   // A vector abort cycle is not a stall for the vector side.
   assign s_stall = s_req && (state != SCALAR);
   assign v_stall = v_req && (state != VECTOR) && !v_abort;

   always_ff @(posedge CLK) begin
      if (RST || perf_clr) begin
         s_stall_cnt <= '0;
         v_stall_cnt <= '0;
      end else begin
         if (s_stall && (s_stall_cnt != '1)) begin
            s_stall_cnt <= s_stall_cnt + CNT_W'(1);
         end
         if (v_stall && (v_stall_cnt != '1)) begin
            v_stall_cnt <= v_stall_cnt + CNT_W'(1);
         end
      end
   end
`else
   localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
